// File: rtl/sram_responder.sv
// Bus-to-asynchronous-SRAM bridge: splits a 16-bit word access into byte strobes
// on an 8-bit SRAM with programmable strobe length and write data-hold recovery.
module sram_responder #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:1] m_addr,
    input  logic [15:0] m_data_out,
    output logic [15:0] m_data_in,
    input  logic        m_access,
    output logic        m_ack,
    input  logic        m_wr_en,
    input  logic [1:0]  m_bytesel,
    output logic [19:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    input  logic [7:0]  sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {StIdle, StLo, StHi, StRecover, StAck} state_e;

    localparam logic [3:0] WaitLast = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:1] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [1:0]  bsel_q, bsel_d;
    logic        hi_q, hi_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic [7:0]  dq_o_q, dq_o_d;
    logic        last;

    // Next-state, transaction latch and read-lane capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        bsel_d  = bsel_q;
        hi_d    = hi_q;
        rdata_d = rdata_q;
        last    = (cnt_q == WaitLast);

        unique case (state_q)
            StIdle: begin
                if (m_access) begin
                    addr_d = m_addr;
                    data_d = m_data_out;
                    wr_d   = m_wr_en;
                    bsel_d = m_bytesel;
                    if (m_bytesel[0]) begin
                        state_d = StLo;
                        hi_d    = 1'b0;
                    end else if (m_bytesel[1]) begin
                        state_d = StHi;
                        hi_d    = 1'b1;
                    end else begin
                        state_d = StAck;
                        // A read with no lanes enabled returns all-zero data.
                        if (!m_wr_en) rdata_d = 16'h0000;
                    end
                end
            end
            StLo: begin
                if (!last) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    if (!wr_q) begin
                        rdata_d[7:0] = sram_dq_i;
                        if (!bsel_q[1]) rdata_d[15:8] = 8'h00;
                    end
                    if (wr_q) begin
                        state_d = StRecover;
                    end else if (bsel_q[1]) begin
                        state_d = StHi;
                        hi_d    = 1'b1;
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StHi: begin
                if (!last) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    if (!wr_q) begin
                        rdata_d[15:8] = sram_dq_i;
                        if (!bsel_q[0]) rdata_d[7:0] = 8'h00;
                    end
                    state_d = wr_q ? StRecover : StAck;
                end
            end
            StRecover: begin
                if (!hi_q && bsel_q[1]) begin
                    state_d = StHi;
                    hi_d    = 1'b1;
                end else begin
                    state_d = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pins are registered from the next state so strobes leave the flops glitch-free.
    always_comb begin
        ack_d       = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;

        unique case (state_d)
            StLo, StHi: begin
                ce_n_d      = 1'b0;
                oe_n_d      = wr_d;
                we_n_d      = !wr_d;
                dq_oe_d     = wr_d;
                sram_addr_d = {addr_d, (state_d == StHi)};
                dq_o_d      = (state_d == StHi) ? data_d[15:8] : data_d[7:0];
            end
            StRecover: dq_oe_d = 1'b1;
            StAck:     ack_d   = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            data_q      <= 16'h0000;
            wr_q        <= 1'b0;
            bsel_q      <= 2'b00;
            hi_q        <= 1'b0;
            rdata_q     <= 16'h0000;
            ack_q       <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            sram_addr_q <= 20'h00000;
            dq_o_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            bsel_q      <= bsel_d;
            hi_q        <= hi_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
        end
    end

    assign m_data_in  = rdata_q;
    assign m_ack      = ack_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (WAIT_STATES=1 and 0) on a shared SRAM model,
// directed cases then random transactions checked against a byte-array reference.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:1] m_addr = '0;
    logic [15:0] m_data_out = 16'h0000;
    logic        m_wr_en = 1'b0;
    logic [1:0]  m_bytesel = 2'b00;
    logic        acc_a = 1'b0, acc_b = 1'b0;
    bit          sel = 1'b0;

    logic [15:0] din_a, din_b;
    logic        ack_a, ack_b, dqoe_a, dqoe_b;
    logic        ce_n_a, ce_n_b, oe_n_a, oe_n_b, we_n_a, we_n_b;
    logic [19:0] sa_a, sa_b;
    logic [7:0]  dqo_a, dqo_b, dqi_a, dqi_b;

    logic [7:0]  srm [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] prev_rd [2];

    int checks = 0;
    int errors = 0;

    logic [63:0] ce_m, oe_m, we_m, rec_m;
    logic [19:0] addr_log [64];
    logic [7:0]  dq_log [64];
    int          ack_cyc;

    always #5 clk = ~clk;

    sram_responder #(.WAIT_STATES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .m_addr(m_addr), .m_data_out(m_data_out),
        .m_data_in(din_a), .m_access(acc_a), .m_ack(ack_a), .m_wr_en(m_wr_en),
        .m_bytesel(m_bytesel), .sram_addr(sa_a), .sram_dq_o(dqo_a), .sram_dq_i(dqi_a),
        .sram_dq_oe(dqoe_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a)
    );

    sram_responder #(.WAIT_STATES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .m_addr(m_addr), .m_data_out(m_data_out),
        .m_data_in(din_b), .m_access(acc_b), .m_ack(ack_b), .m_wr_en(m_wr_en),
        .m_bytesel(m_bytesel), .sram_addr(sa_b), .sram_dq_o(dqo_b), .sram_dq_i(dqi_b),
        .sram_dq_oe(dqoe_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Asynchronous SRAM: drives data only while selected and output-enabled.
    assign dqi_a = (!ce_n_a && !oe_n_a) ? srm[sa_a[7:0]] : 8'hee;
    assign dqi_b = (!ce_n_b && !oe_n_b) ? srm[sa_b[7:0]] : 8'hee;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) srm[i] <= init_byte(i);
        end else begin
            if (!ce_n_a && !we_n_a && dqoe_a) srm[sa_a[7:0]] <= dqo_a;
            if (!ce_n_b && !we_n_b && dqoe_b) srm[sa_b[7:0]] <= dqo_b;
        end
    end

    logic [15:0] o_din;
    logic        o_ack, o_ce_n, o_oe_n, o_we_n, o_dqoe;
    logic [19:0] o_addr;
    logic [7:0]  o_dqo;
    assign o_din  = sel ? din_b  : din_a;
    assign o_ack  = sel ? ack_b  : ack_a;
    assign o_ce_n = sel ? ce_n_b : ce_n_a;
    assign o_oe_n = sel ? oe_n_b : oe_n_a;
    assign o_we_n = sel ? we_n_b : we_n_a;
    assign o_dqoe = sel ? dqoe_b : dqoe_a;
    assign o_addr = sel ? sa_b   : sa_a;
    assign o_dqo  = sel ? dqo_b  : dqo_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic init_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        prev_rd[0] = 16'h0000;
        prev_rd[1] = 16'h0000;
    endtask

    // One transaction; cycle 0 is the cycle in which the idle responder sees m_access.
    task automatic xact(input bit s, input bit wr, input logic [19:1] a, input logic [15:0] d,
                        input logic [1:0] bs, input bit drop, input bit keep);
        int ws, n, exp_ack, cyc, ce_cnt, lo, hi;
        bit got;
        logic [15:0] exp_rd, rd_at_ack;
        ws = s ? 0 : 1;
        n = int'(bs[0]) + int'(bs[1]);
        exp_ack = (n == 0) ? 1 : (wr ? n * (ws + 2) + 1 : n * (ws + 1) + 1);
        lo = int'({a[7:1], 1'b0});
        hi = lo + 1;
        exp_rd = wr ? prev_rd[s] : {bs[1] ? ref_mem[hi] : 8'h00, bs[0] ? ref_mem[lo] : 8'h00};
        @(negedge clk);
        sel = s;
        check("idle_no_ack", 32'(o_ack), 32'd0);
        m_addr = a;
        m_data_out = d;
        m_wr_en = wr;
        m_bytesel = bs;
        if (s) acc_b = 1'b1; else acc_a = 1'b1;
        ce_m = '0; oe_m = '0; we_m = '0; rec_m = '0;
        cyc = 0; got = 1'b0; ce_cnt = 0; ack_cyc = 0; rd_at_ack = 16'h0000;
        while (!got && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (drop && cyc == 1) begin
                acc_a = 1'b0;
                acc_b = 1'b0;
            end
            ce_m[cyc]  = !o_ce_n;
            oe_m[cyc]  = !o_oe_n;
            we_m[cyc]  = !o_we_n;
            rec_m[cyc] = o_ce_n && o_dqoe;
            addr_log[cyc] = o_addr;
            dq_log[cyc]   = o_dqo;
            check("dq_oe_vs_oe_n", 32'(o_dqoe & ~o_oe_n), 32'd0);
            if (!o_ce_n) ce_cnt++;
            if (o_ack) begin
                got = 1'b1;
                ack_cyc = cyc;
                rd_at_ack = o_din;
                check("ack_strobes_idle", 32'({o_ce_n, o_oe_n, o_we_n, o_dqoe}), 32'hE);
            end
        end
        if (!keep) begin
            acc_a = 1'b0;
            acc_b = 1'b0;
        end
        check("ack_latency", got ? 32'(ack_cyc) : 32'hffff_ffff, 32'(exp_ack));
        check("strobe_cycles", 32'(ce_cnt), 32'(n * (ws + 1)));
        check("m_data_in", 32'(rd_at_ack), 32'(exp_rd));
        if (wr) begin
            if (bs[0]) ref_mem[lo] = d[7:0];
            if (bs[1]) ref_mem[hi] = d[15:8];
        end else begin
            prev_rd[s] = exp_rd;
        end
    endtask

    initial begin
        bit keep_prev, s_prev, s, wr, drop, keep;
        init_ref();

        // Reset holds everything quiet even with a request pending.
        acc_a = 1'b1;
        m_bytesel = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check("rst_strobes", 32'({ce_n_a, oe_n_a, we_n_a, dqoe_a}), 32'hE);
            check("rst_ack_data", 32'({ack_a, din_a}), 32'd0);
            check("rst_addr_dq", 32'({sa_a, dqo_a}), 32'd0);
        end
        acc_a = 1'b0;
        reset_n = 1'b1;

        // Word write 0xBEEF with full waveform check.
        xact(1'b0, 1'b1, 19'h30, 16'hBEEF, 2'b11, 1'b0, 1'b0);
        check("beef_ack", 32'(ack_cyc), 32'd7);
        check("beef_we_mask", ce_m[31:0] & we_m[31:0], 32'h36);
        check("beef_recover", rec_m[31:0], 32'h48);
        check("beef_addr_lo", 32'(addr_log[1]), 32'h60);
        check("beef_dq_lo", 32'(dq_log[2]), 32'hEF);
        check("beef_addr_hi", 32'(addr_log[4]), 32'h61);
        check("beef_dq_hi", 32'(dq_log[5]), 32'hBE);

        // Word read of bytes A5/3C at byte address 0x20.
        xact(1'b0, 1'b1, 19'h10, 16'h3CA5, 2'b11, 1'b0, 1'b0);
        xact(1'b0, 1'b0, 19'h10, 16'h0000, 2'b11, 1'b0, 1'b0);
        check("rd_ack", 32'(ack_cyc), 32'd5);
        check("rd_oe_mask", oe_m[31:0], 32'h1E);
        check("rd_data", 32'(prev_rd[0]), 32'h3CA5);

        // No lanes enabled: immediate ack, no SRAM activity.
        xact(1'b0, 1'b1, 19'h10, 16'h1111, 2'b00, 1'b0, 1'b0);
        check("bs00_wr_ce", ce_m[31:0], 32'd0);
        xact(1'b0, 1'b0, 19'h10, 16'h0000, 2'b00, 1'b0, 1'b0);
        check("bs00_rd_ce", ce_m[31:0], 32'd0);

        // Zero wait states, high byte only.
        xact(1'b1, 1'b1, 19'h21, 16'h7712, 2'b10, 1'b0, 1'b0);
        xact(1'b1, 1'b0, 19'h21, 16'h0000, 2'b10, 1'b0, 1'b0);
        check("hi_ack", 32'(ack_cyc), 32'd2);
        check("hi_ce_mask", ce_m[31:0], 32'h2);
        check("hi_data", 32'(prev_rd[1]), 32'h7700);

        // Request dropped mid-transaction, then back-to-back reads.
        xact(1'b0, 1'b1, 19'h05, 16'hA1B2, 2'b11, 1'b1, 1'b0);
        xact(1'b0, 1'b0, 19'h05, 16'h0000, 2'b11, 1'b0, 1'b1);
        xact(1'b0, 1'b0, 19'h30, 16'h0000, 2'b11, 1'b0, 1'b0);

        // Reset during the high-byte strobe of a word write.
        @(negedge clk);
        sel = 1'b0;
        m_addr = 19'h40;
        m_data_out = 16'h1234;
        m_wr_en = 1'b1;
        m_bytesel = 2'b11;
        acc_a = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_hi_addr", 32'(sa_a), 32'h81);
        reset_n = 1'b0;
        acc_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_strobes", 32'({ce_n_a, oe_n_a, we_n_a, dqoe_a}), 32'hE);
        check("mid_rst_ack", 32'(ack_a), 32'd0);
        check("mid_rst_addr", 32'({sa_a, dqo_a}), 32'd0);
        reset_n = 1'b1;
        init_ref();
        xact(1'b0, 1'b1, 19'h40, 16'h1234, 2'b11, 1'b0, 1'b0);
        xact(1'b0, 1'b0, 19'h40, 16'h0000, 2'b11, 1'b0, 1'b0);

        // Random mix on both instances, readbacks go through the shared SRAM.
        keep_prev = 1'b0;
        s_prev = 1'b0;
        for (int i = 0; i < 80; i++) begin
            s    = keep_prev ? s_prev : 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 4) == 0);
            keep = (i < 79) && ($urandom_range(0, 3) == 0);
            xact(s, wr, 19'($urandom_range(0, 127)), 16'($urandom),
                 2'($urandom_range(0, 3)), drop, keep);
            keep_prev = keep;
            s_prev = s;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter WAIT_STATES, default 1, SHALL set extra strobe cycles per SRAM byte access; legal range 0..15.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 m_addr  input  19 [19:1]  SHALL carry the bus word address.
REQ-005 m_data_out  input  16  SHALL carry the write data from the bus initiator.
REQ-006 m_data_in  output  16  SHALL carry the read data returned to the initiator.
REQ-007 m_access  input  1  SHALL carry the transaction request, held by the initiator until m_ack.
REQ-008 m_ack  output  1  SHALL be a single-cycle completion pulse.
REQ-009 m_wr_en  input  1  SHALL select the direction: 1 write, 0 read.
REQ-010 m_bytesel  input  2  SHALL be the byte-lane enables: bit0 low byte, bit1 high byte.
REQ-011 sram_addr  output  20  SHALL carry the registered SRAM byte address.
REQ-012 sram_dq_o  output  8  SHALL carry the SRAM write data.
REQ-013 sram_dq_i  input  8  SHALL carry the SRAM read data.
REQ-014 sram_dq_oe  output  1  SHALL enable the data bus driver (1 = drive).
REQ-015 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SHALL be the active-low SRAM strobes.

Function
REQ-016 FSM states SHALL be IDLE, LO, HI, RECOVER, ACK; 4-bit wait counter.
REQ-017 IDLE, m_access=1: latch m_addr, m_data_out, m_wr_en, m_bytesel; next state = LO if bytesel[0], else HI if bytesel[1], else ACK.
REQ-018 LO/HI strobe length SHALL be WAIT_STATES+1 cycles: ce_n=0; reads oe_n=0, we_n=1; writes we_n=0, oe_n=1.
REQ-019 sram_addr SHALL be {addr,1'b0} in LO and {addr,1'b1} in HI.
REQ-020 sram_dq_o SHALL be the latched data[7:0] in LO and data[15:8] in HI.
REQ-021 Reads: sram_dq_i SHALL be captured into the matching m_data_in lane on the last strobe cycle; unselected lanes SHALL read 8'h00.
REQ-022 Writes: each strobe SHALL be followed by one RECOVER cycle (ce_n=1, we_n=1, dq_oe=1, address/data held) for data hold.
REQ-023 sram_dq_oe SHALL be 1 only during write LO/HI/RECOVER; it SHALL never be 1 while oe_n=0.
REQ-024 After LO (+RECOVER): go to HI if bytesel[1], else ACK; after HI (+RECOVER): go to ACK.
REQ-025 ACK SHALL last exactly one cycle with m_ack=1 and all strobes inactive, then return to IDLE; IDLE SHALL NOT accept m_access in that same cycle.
REQ-026 Latency from the access-sample cycle (cycle 0), n = enabled bytes: read ack at cycle n*(WAIT_STATES+1)+1; write ack at cycle n*(WAIT_STATES+2)+1; bytesel=00 ack at cycle 1 with no SRAM activity.
REQ-027 m_data_in SHALL be valid in the ACK cycle and SHALL hold until the next read capture; writes SHALL NOT alter it.
REQ-028 Deassertion of m_access mid-transaction SHALL be ignored; the latched transaction SHALL complete and ack.
REQ-029 Back-to-back: m_access high in the cycle after ACK SHALL start a new transaction from IDLE.

Reset
REQ-030 reset_n=0 at any edge, including mid-transaction, SHALL force IDLE, counter=0, m_ack=0, m_data_in=16'h0000, sram_ce_n/oe_n/we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0 on that edge.
REQ-031 The first transaction SHALL be accepted no earlier than the first edge with reset_n=1.

Verification
REQ-032 WS=1, read, addr=19'h00010, bytesel=11, SRAM bytes 0x20=A5, 0x21=3C -> m_ack at cycle 5, m_data_in=16'h3CA5, oe_n low cycles 1-4.
REQ-033 WS=1, write, data=16'hBEEF, bytesel=11 -> we_n low cycles 1-2 (addr even, dq EF) and 4-5 (addr odd, dq BE), RECOVER at 3 and 6, ack at 7.
REQ-034 WS=0, read, bytesel=10, high byte 0x77 -> single HI strobe at cycle 1, ack at 2, m_data_in=16'h7700.
REQ-035 bytesel=00 read or write -> ack at cycle 1, ce_n held 1 throughout, m_data_in unchanged on write.
REQ-036 reset_n low in HI state of a word write -> next edge all strobes inactive, dq_oe=0, no ack; the following request completes normally.
REQ-037 Two back-to-back reads with m_access held continuously -> two separate acks, no strobes in either ACK cycle, ce_n never overlaps dq_oe with oe_n=0.
